// File: rtl/m2v_fb_pkg.sv
// Shared constants and types for the MPEG2 frame-buffer scan-out reader:
// address field offsets, per-quad read order, and the pixel bundle.
package m2v_fb_pkg;

  localparam int OFS_SEL  = 1;
  localparam int OFS_Q    = 2;
  localparam int OFS_YLSB = 4;
  localparam int OFS_YROW = 5;
  localparam int OFS_MBX  = 8;

  // Word slots within one quad, in the order they are requested and buffered
  localparam logic [1:0] RD_L0 = 2'd0;
  localparam logic [1:0] RD_L1 = 2'd1;
  localparam logic [1:0] RD_CB = 2'd2;
  localparam logic [1:0] RD_CR = 2'd3;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sof;
    logic       eol;
  } pix_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

endpackage

// File: rtl/m2vfbread_fifo.sv
// Return-word buffer: single-word push, four-word pop, with the four head
// words exposed so a whole quad can be read without popping.
module m2vfbread_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [15:0]              wdata,
  input  logic                     pop4,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0][15:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop4) rd_ptr <= rd_ptr + AW'(4);
      count <= count + CW'(push) - (pop4 ? CW'(4) : CW'(0));
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) head[i] = mem[rd_ptr + AW'(i)];
  end

endmodule

// File: rtl/m2vfbread.sv
// Raster scan-out reader: walks the macroblock-tiled frame buffer line by line,
// issues pipelined 16-bit reads and emits Y/Cb/Cr pixels in raster order.
module m2vfbread
  import m2v_fb_pkg::*;
#(
  parameter int MEM_WIDTH  = 21,
  parameter int MBX_WIDTH  = 6,
  parameter int MBY_WIDTH  = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  frame,
  input  logic [MBX_WIDTH-1:0]  mbw,
  input  logic [MBY_WIDTH-1:0]  mbh,
  output logic                  busy,
  output logic                  done,
  output logic [MEM_WIDTH-1:0]  m_address,
  output logic                  m_read,
  input  logic                  m_waitrequest,
  input  logic [15:0]           m_readdata,
  input  logic                  m_readdatavalid,
  output logic [7:0]            pix_y,
  output logic [7:0]            pix_cb,
  output logic [7:0]            pix_cr,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int SW      = CW + 1;
  localparam int OFS_MBY = OFS_MBX + MBX_WIDTH;
  localparam int OFS_CHR = OFS_MBY + MBY_WIDTH;
  localparam int OFS_FRM = OFS_CHR + 1;

  state_t                state, state_nx;
  logic                  frame_r;
  logic [MBX_WIDTH-1:0]  mbw_r, mbx_last;
  logic [MBY_WIDTH-1:0]  mbh_r, mby_last;
  logic [1:0]            ird, iq, ok, oq;
  logic [3:0]            iy, oy;
  logic [MBX_WIDTH-1:0]  ibx, obx;
  logic [MBY_WIDTH-1:0]  iby, oby;
  logic [CW-1:0]         pending, fifo_count;
  logic [3:0][15:0]      head;
  logic                  active, accept, ret, xfer, pop4;
  logic                  last_req, last_pix, zero_size, done_set;
  pix_t                  pix;

  assign active    = (state != ST_IDLE);
  assign busy      = active;
  assign mbx_last  = mbw_r - MBX_WIDTH'(1);
  assign mby_last  = mbh_r - MBY_WIDTH'(1);
  assign zero_size = (mbw == '0) || (mbh == '0);

  // Credit check covers both in-flight words and words already buffered
  assign m_read = (state == ST_RUN) &&
                  (({1'b0, pending} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH));
  assign accept = m_read && !m_waitrequest;
  assign ret    = m_readdatavalid && active;

  assign pix_valid = active && (fifo_count >= CW'(4));
  assign xfer      = pix_valid && pix_ready;
  assign pop4      = xfer && (ok == 2'd3);

  assign last_req = (ird == 2'd3) && (iq == 2'd3) && (iy == 4'd15) &&
                    (ibx == mbx_last) && (iby == mby_last);
  assign last_pix = (ok == 2'd3) && (oq == 2'd3) && (oy == 4'd15) &&
                    (obx == mbx_last) && (oby == mby_last);

  m2vfbread_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ret),
    .wdata   (m_readdata),
    .pop4    (pop4),
    .count   (fifo_count),
    .head    (head)
  );

  // Chroma words drop the line LSB so each chroma row serves a line pair
  always_comb begin
    m_address                        = '0;
    m_address[OFS_SEL]               = ird[0];
    m_address[OFS_Q +: 2]            = iq;
    m_address[OFS_YLSB]              = ird[1] ? 1'b0 : iy[0];
    m_address[OFS_YROW +: 3]         = iy[3:1];
    m_address[OFS_MBX +: MBX_WIDTH]  = ibx;
    m_address[OFS_MBY +: MBY_WIDTH]  = iby;
    m_address[OFS_CHR]               = ird[1];
    m_address[OFS_FRM]               = frame_r;
  end

  always_comb begin
    pix.y   = ok[1] ? (ok[0] ? head[RD_L1][15:8] : head[RD_L1][7:0])
                    : (ok[0] ? head[RD_L0][15:8] : head[RD_L0][7:0]);
    pix.cb  = ok[1] ? head[RD_CB][15:8] : head[RD_CB][7:0];
    pix.cr  = ok[1] ? head[RD_CR][15:8] : head[RD_CR][7:0];
    pix.sof = (ok == 2'd0) && (oq == 2'd0) && (obx == '0) && (oy == 4'd0) && (oby == '0);
    pix.eol = (ok == 2'd3) && (oq == 2'd3) && (obx == mbx_last);
    if (!pix_valid) pix = '0;
  end

  assign pix_y   = pix.y;
  assign pix_cb  = pix.cb;
  assign pix_cr  = pix.cr;
  assign pix_sof = pix.sof;
  assign pix_eol = pix.eol;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (zero_size) done_set = 1'b1;
          else           state_nx = ST_RUN;
        end
      end
      ST_RUN:   if (accept && last_req) state_nx = ST_FLUSH;
      ST_FLUSH: state_nx = ST_FLUSH;
      default:  state_nx = ST_IDLE;
    endcase
    if (xfer && last_pix) begin
      state_nx = ST_IDLE;
      done_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      frame_r <= 1'b0;
      mbw_r   <= '0;
      mbh_r   <= '0;
      pending <= '0;
      ird <= '0; iq <= '0; iy <= '0; ibx <= '0; iby <= '0;
      ok  <= '0; oq <= '0; oy <= '0; obx <= '0; oby <= '0;
    end else begin
      done    <= done_set;
      pending <= pending + CW'(accept) - CW'(ret);
      if (start && !active) begin
        frame_r <= frame;
        mbw_r   <= mbw;
        mbh_r   <= mbh;
        ird <= '0; iq <= '0; iy <= '0; ibx <= '0; iby <= '0;
        ok  <= '0; oq <= '0; oy <= '0; obx <= '0; oby <= '0;
      end else begin
        if (accept) begin
          ird <= ird + 2'd1;
          if (ird == 2'd3) begin
            iq <= iq + 2'd1;
            if (iq == 2'd3) begin
              if (ibx == mbx_last) begin
                ibx <= '0;
                iy  <= iy + 4'd1;
                if (iy == 4'd15) iby <= iby + MBY_WIDTH'(1);
              end else begin
                ibx <= ibx + MBX_WIDTH'(1);
              end
            end
          end
        end
        if (xfer) begin
          ok <= ok + 2'd1;
          if (ok == 2'd3) begin
            oq <= oq + 2'd1;
            if (oq == 2'd3) begin
              if (obx == mbx_last) begin
                obx <= '0;
                oy  <= oy + 4'd1;
                if (oy == 4'd15) oby <= oby + MBY_WIDTH'(1);
              end else begin
                obx <= obx + MBX_WIDTH'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_m2vfbread.sv
// Bench for the frame-buffer scan-out reader: Avalon memory responder with
// optional random stalls/latency, and a raster-order reference of every read and pixel.
module tb_m2vfbread;

  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        frame = 1'b0;
  logic [5:0]  mbw = '0;
  logic [4:0]  mbh = '0;
  logic        busy, done;
  logic [20:0] m_address;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [15:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [7:0]  pix_y, pix_cb, pix_cr;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_sof, pix_eol;

  m2vfbread dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .frame           (frame),
    .mbw             (mbw),
    .mbh             (mbh),
    .busy            (busy),
    .done            (done),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .pix_y           (pix_y),
    .pix_cb          (pix_cb),
    .pix_cr          (pix_cr),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sof;
    logic       eol;
  } epix_t;

  typedef struct {
    logic [15:0] d;
    int          due;
  } rsp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_mem = 1'b0;
  bit stall = 1'b0;
  int n_acc, n_pix, n_eol, n_sof, n_done, popped_words;
  epix_t       exp_pix[$];
  logic [20:0] exp_addr[$];
  logic [20:0] rd_log[$];
  rsp_t        rq[$];
  rsp_t        r;
  epix_t       e;
  bit          prev_wait = 1'b0;
  logic [20:0] prev_addr = '0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_pix = '0;
  int          n_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [20:0] addr_of(int f, int chroma, int sel, int q, int y, int bx, int by);
    int a;
    a = (f << 20) + (chroma << 19) + (by << 14) + (bx << 8) + ((y / 2) << 5) +
        ((chroma != 0 ? 0 : (y % 2)) << 4) + (q << 2) + (sel << 1);
    return 21'(a);
  endfunction

  function automatic logic [15:0] mem_data(logic [20:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E3779B1;
    return t[31:16] ^ t[15:0];
  endfunction

  // Expected reads and pixels, straight from the raster walk over the tiled layout
  task automatic build(input int f, input int w, input int h);
    logic [20:0] la [4];
    logic [15:0] wd [4];
    epix_t p;
    exp_pix.delete();
    exp_addr.delete();
    for (int by = 0; by < h; by++)
      for (int y = 0; y < 16; y++)
        for (int bx = 0; bx < w; bx++)
          for (int q = 0; q < 4; q++) begin
            la[0] = addr_of(f, 0, 0, q, y, bx, by);
            la[1] = addr_of(f, 0, 1, q, y, bx, by);
            la[2] = addr_of(f, 1, 0, q, y, bx, by);
            la[3] = addr_of(f, 1, 1, q, y, bx, by);
            for (int i = 0; i < 4; i++) begin
              exp_addr.push_back(la[i]);
              wd[i] = mem_data(la[i]);
            end
            for (int k = 0; k < 4; k++) begin
              p.y   = (k % 2 == 1) ? wd[k / 2][15:8] : wd[k / 2][7:0];
              p.cb  = (k >= 2) ? wd[2][15:8] : wd[2][7:0];
              p.cr  = (k >= 2) ? wd[3][15:8] : wd[3][7:0];
              p.sof = (by == 0 && y == 0 && bx == 0 && q == 0 && k == 0);
              p.eol = (k == 3 && q == 3 && bx == w - 1);
              exp_pix.push_back(p);
            end
          end
  endtask

  // Memory responder, bus-rule checks and pixel scoreboard, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      rq.delete();
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
      prev_wait       = 1'b0;
      hold_prev       = 1'b0;
    end else begin
      m_waitrequest = rand_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = rq[0].d;
        void'(rq.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = 16'($urandom);
      end
      pix_ready = stall ? 1'b0 : 1'b1;

      if (prev_wait) begin
        chk("hold_read", 32'(m_read), 32'd1);
        chk("hold_addr", 32'(m_address), 32'(prev_addr));
      end
      prev_wait = m_read && m_waitrequest;
      prev_addr = m_address;
      if (m_read && !m_waitrequest) begin
        chk("credit", 32'((n_acc - popped_words) < FD), 32'd1);
        if (exp_addr.size() == 0) chk("extra_read", 32'd1, 32'd0);
        else chk("addr", 32'(m_address), 32'(exp_addr.pop_front()));
        r.d   = mem_data(m_address);
        r.due = cyc + (rand_mem ? int'($urandom_range(1, 6)) : 1);
        rq.push_back(r);
        rd_log.push_back(m_address);
        n_acc++;
      end

      if (hold_prev)
        chk("hold_pix", 32'({pix_valid, pix_y, pix_cb, pix_cr, pix_sof, pix_eol}), prev_pix);
      hold_prev = pix_valid && !pix_ready;
      prev_pix  = 32'({pix_valid, pix_y, pix_cb, pix_cr, pix_sof, pix_eol});
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) chk("extra_pix", 32'd1, 32'd0);
        else begin
          e = exp_pix.pop_front();
          chk("pix", 32'({pix_y, pix_cb, pix_cr, pix_sof, pix_eol}),
              32'({e.y, e.cb, e.cr, e.sof, e.eol}));
        end
        n_pix++;
        if (pix_eol) n_eol++;
        if (pix_sof) n_sof++;
        if (n_pix % 4 == 0) popped_words += 4;
      end

      if (done) begin
        n_done++;
        chk("done_drained", 32'(exp_pix.size() + exp_addr.size()), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic clear_counts();
    n_acc = 0; n_pix = 0; n_eol = 0; n_sof = 0; n_done = 0; popped_words = 0;
    rd_log.delete();
  endtask

  task automatic start_frame(input int f, input int w, input int h);
    clear_counts();
    build(f, w, h);
    frame = 1'(f);
    mbw   = 6'(w);
    mbh   = 5'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
    #1;
    chk("done_seen", 32'(n_done != 0), 32'd1);
  endtask

  task automatic wait_pix(input int n, input int budget);
    for (int i = 0; i < budget && n_pix < n; i++) @(posedge clk);
    #1;
    chk("pix_progress", 32'(n_pix >= n), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_read"}, 32'(m_read), 32'd0);
    chk({tag, "_addr"}, 32'(m_address), 32'd0);
    chk({tag, "_pix"}, 32'({pix_valid, pix_y, pix_cb, pix_cr, pix_sof, pix_eol}), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1x1 macroblock, frame 1, zero-wait memory
    start_frame(1, 1, 1);
    wait_done(3000);
    chk("t1_a0", 32'(rd_log[0]), 32'h100000);
    chk("t1_a1", 32'(rd_log[1]), 32'h100002);
    chk("t1_a2", 32'(rd_log[2]), 32'h180000);
    chk("t1_a3", 32'(rd_log[3]), 32'h180002);
    chk("t1_y1_l0", 32'(rd_log[16]), 32'h100010);
    chk("t1_y1_cb", 32'(rd_log[18]), 32'h180000);
    chk("t1_reads", 32'(n_acc), 32'd256);
    chk("t1_pixels", 32'(n_pix), 32'd256);
    chk("t1_eol", 32'(n_eol), 32'd16);
    chk("t1_sof", 32'(n_sof), 32'd1);
    chk("t1_done", 32'(n_done), 32'd1);

    // 2x2 macroblocks, zero-wait memory
    start_frame(1, 2, 2);
    wait_done(6000);
    chk("t2_mbx1", 32'(rd_log[16]), 32'h100100);
    chk("t2_mby1", 32'(rd_log[512]), 32'h104000);
    chk("t2_pixels", 32'(n_pix), 32'd1024);
    chk("t2_eol", 32'(n_eol), 32'd32);

    // 2x2 with random stalls and latency; a second start mid-frame is ignored
    rand_mem = 1'b1;
    start_frame(1, 2, 2);
    repeat (50) @(posedge clk);
    #1;
    frame = 1'b0; mbw = 6'd3; mbh = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_busy_kept", 32'(busy), 32'd1);
    wait_done(20000);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_pixels", 32'(n_pix), 32'd1024);
    chk("t3_reads", 32'(n_acc), 32'd1024);
    chk("t3_one_done", 32'(n_done), 32'd1);

    // Sink stalls for 100 cycles mid-line
    start_frame(0, 1, 1);
    wait_pix(6, 2000);
    stall = 1'b1;
    n_before = n_pix;
    repeat (100) @(posedge clk);
    #1;
    chk("t4_no_read", 32'(m_read), 32'd0);
    chk("t4_buffer_full", 32'(n_acc - popped_words), 32'(FD));
    chk("t4_no_pix", 32'(n_pix), 32'(n_before));
    chk("t4_valid_held", 32'(pix_valid), 32'd1);
    stall = 1'b0;
    wait_done(6000);
    chk("t4_pixels", 32'(n_pix), 32'd256);
    rand_mem = 1'b0;

    // Reset mid-frame, then a fresh frame
    start_frame(1, 1, 1);
    wait_pix(50, 2000);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    exp_pix.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("abort_hold");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done), 32'd0);
    start_frame(1, 1, 1);
    wait_done(3000);
    chk("t5_first_addr", 32'(rd_log[0]), 32'h100000);
    chk("t5_sof", 32'(n_sof), 32'd1);
    chk("t5_pixels", 32'(n_pix), 32'd256);

    // Zero-width start
    clear_counts();
    exp_pix.delete();
    exp_addr.delete();
    frame = 1'b1; mbw = 6'd0; mbh = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_read", 32'(m_read), 32'd0);
    @(posedge clk); #1;
    chk("zero_done_pulse", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_no_reads", 32'(n_acc), 32'd0);
    chk("zero_one_done", 32'(n_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
